// File: rtl/alu_seq.sv
// +--------------------------------------------------------------------+
// | alu_seq : 4x8 register file sequencing commands through an external |
// | LAT-cycle ALU, with a one-cycle result pulse.        Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_seq #(
    parameter int LAT = 2
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic [1:0] cmd_rd,
    input  logic       ld_valid,
    input  logic [1:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_ctr,
    input  logic [7:0] alu_o,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    // WAIT spans LAT-1 cycles; with LAT of 1 it is skipped entirely.
    localparam logic [2:0] CNT_LAST  = (LAT >= 2) ? 3'(LAT - 2) : 3'd0;
    localparam bit         SKIP_WAIT = (LAT <= 1);

    logic [1:0] state;
    logic [1:0] next_state;
    logic [2:0] cnt;
    logic       started;
    logic [1:0] rd_q;
    logic [7:0] regs [4];

    logic accept;
    logic op_legal;
    logic writeback;

    assign accept    = cmd_valid && cmd_ready;
    assign op_legal  = (cmd_op == 4'b0000) || (cmd_op == 4'b0001) || cmd_op[3];
    assign writeback = (state == S_WB);

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept && op_legal) next_state = S_ISSUE;
            S_ISSUE: next_state = SKIP_WAIT ? S_WB : S_WAIT;
            S_WAIT:  if (cnt == CNT_LAST) next_state = S_WB;
            S_WB:    next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // started keeps cmd_ready low until the first edge after reset release.
    always_comb begin
        cmd_ready = started && (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 3'd0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (state == S_WAIT) begin
                cnt <= cnt + 3'd1;
            end else begin
                cnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            alu_ctr <= 4'b0000;
            rd_q    <= 2'd0;
        end else if (accept && op_legal) begin
            alu_a   <= regs[cmd_ra];
            alu_b   <= regs[cmd_rb];
            alu_ctr <= cmd_op;
            rd_q    <= cmd_rd;
        end
    end

    // Writeback is assigned after the load so it wins on a shared target.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ld_valid && (ld_addr == 2'(i))) begin
                    regs[i] <= ld_data;
                end
                if (writeback && (rd_q == 2'(i))) begin
                    regs[i] <= alu_o;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            res_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (writeback) begin
                res_valid <= 1'b1;
                res_data  <= alu_o;
                res_err   <= 1'b0;
            end else if (accept && !op_legal) begin
                res_valid <= 1'b1;
                res_data  <= 8'h00;
                res_err   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +--------------------------------------------------------------------+
// | tb_alu_seq : directed and random checks of alu_seq against a       |
// | timeline reference model.                            Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

    localparam int LAT = 2;

    logic       ck = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_ra, cmd_rb, cmd_rd;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_ctr;
    logic [7:0] alu_o;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.LAT(LAT)) dut (
        .ck(ck), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .busy(busy)
    );

    always #5 ck = ~ck;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h8: return a & b;
            4'h9: return a | b;
            4'hA: return a ^ b;
            4'hB: return ~a;
            4'hC: return a << 1;
            4'hD: return a >> 1;
            4'hE: return a + 8'd1;
            default: return b;
        endcase
    endfunction

    // External ALU: result appears LAT edges after the operands change.
    logic [7:0] pipe [LAT];
    always @(posedge ck) begin
        pipe[0] <= alu_fn(alu_a, alu_b, alu_ctr);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_o = pipe[LAT-1];

    // Reference model: a command completes LAT+1 edges after acceptance.
    logic [7:0] mregs [4];
    bit         m_started, m_pend, m_rvalid, m_rerr;
    int         m_done, cyc;
    logic [1:0] m_rd;
    logic [7:0] m_res, m_a, m_b, m_rdata;
    logic [3:0] m_ctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        m_started = 0; m_pend = 0; m_rvalid = 0; m_rerr = 0;
        m_rd = 0; m_res = 0; m_a = 0; m_b = 0; m_ctr = 0; m_rdata = 0;
    endtask

    task automatic model_edge();
        logic [7:0] old [4];
        bit ready_before;
        cyc++;
        if (!rst_n) return;
        m_rvalid = 0;
        ready_before = m_started && !m_pend;
        for (int i = 0; i < 4; i++) old[i] = mregs[i];
        if (ld_valid) mregs[ld_addr] = ld_data;
        if (m_pend && cyc == m_done) begin
            mregs[m_rd] = m_res;
            m_rdata = m_res; m_rerr = 0; m_rvalid = 1; m_pend = 0;
        end
        if (cmd_valid && ready_before) begin
            if (cmd_op <= 4'd1 || cmd_op >= 4'd8) begin
                m_a = old[cmd_ra]; m_b = old[cmd_rb]; m_ctr = cmd_op; m_rd = cmd_rd;
                m_res = alu_fn(m_a, m_b, cmd_op);
                m_done = cyc + LAT + 1;
                m_pend = 1;
            end else begin
                m_rvalid = 1; m_rerr = 1; m_rdata = 8'h00;
            end
        end
        m_started = 1;
    endtask

    task automatic check_all();
        chk("cmd_ready", cmd_ready, m_started && !m_pend);
        chk("busy", busy, m_pend);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_ctr", alu_ctr, m_ctr);
        chk("res_valid", res_valid, m_rvalid);
        chk("res_data", res_data, m_rdata);
        chk("res_err", res_err, m_rerr);
    endtask

    task automatic tick();
        @(posedge ck);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_op = 0; cmd_ra = 0; cmd_rb = 0; cmd_rd = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        ld_valid = 1; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [1:0] rd);
        cmd_valid = 1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
        tick();
        cmd_valid = 0;
    endtask

    // Returns the number of edges until res_valid; flags a timeout.
    task automatic wait_res(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < 20);
        if (!res_valid) chk("res_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        cyc = 0;
        idle_inputs();
        model_reset();
        rst_n = 0;
        #3;
        check_all();
        repeat (2) tick();
        #2 rst_n = 1;
        chk("ready_pre_edge", cmd_ready, 1'b0);
        tick();
        chk("ready_after_rel", cmd_ready, 1'b1);

        // Add with load-then-issue; latency LAT+1.
        do_load(2'd0, 8'h3C);
        do_load(2'd1, 8'h05);
        issue(4'h0, 2'd0, 2'd1, 2'd2);
        wait_res(n);
        chk("add_latency", n, LAT + 1);
        chk("add_result", res_data, 8'h41);
        issue(4'hF, 2'd0, 2'd2, 2'd3);
        chk("regs2_readback", alu_b, 8'h41);
        wait_res(n);

        // Subtraction wraps.
        do_load(2'd0, 8'h02);
        issue(4'h1, 2'd0, 2'd1, 2'd3);
        wait_res(n);
        chk("sub_wrap", res_data, 8'hFD);
        chk("sub_err", res_err, 1'b0);

        // Illegal opcode: immediate error pulse, no ALU drive.
        issue(4'h4, 2'd1, 2'd2, 2'd0);
        chk("illegal_valid", res_valid, 1'b1);
        chk("illegal_err", res_err, 1'b1);
        chk("illegal_data", res_data, 8'h00);
        chk("illegal_ctr", alu_ctr, 4'h1);
        chk("illegal_ready", cmd_ready, 1'b1);
        tick();

        // Back-to-back with cmd_valid held high.
        cmd_valid = 1; cmd_op = 4'h8; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd1;
        tick();
        cmd_op = 4'hF;
        wait_res(n);
        chk("b2b_ready_with_res", cmd_ready, 1'b1);
        tick();
        cmd_valid = 0;
        chk("b2b_second_busy", busy, 1'b1);
        wait_res(n);
        chk("b2b_spacing", n + 1, LAT + 2);

        // Load and writeback collide on regs[2]; writeback wins.
        do_load(2'd1, 8'h05);
        issue(4'h0, 2'd0, 2'd1, 2'd2);
        repeat (LAT) tick();
        ld_valid = 1; ld_addr = 2'd2; ld_data = 8'hAA;
        tick();
        ld_valid = 0;
        chk("collide_valid", res_valid, 1'b1);
        issue(4'hE, 2'd2, 2'd2, 2'd0);
        chk("collide_regs2", alu_a, 8'h07);
        wait_res(n);

        // Reset mid-WAIT aborts the command.
        issue(4'h9, 2'd0, 2'd1, 2'd3);
        tick();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        repeat (2) tick();
        #2 rst_n = 1;
        chk("rst_ready_pre", cmd_ready, 1'b0);
        tick();
        chk("rst_ready_post", cmd_ready, 1'b1);
        repeat (LAT + 2) begin
            tick();
            chk("rst_no_valid", res_valid, 1'b0);
        end

        // Random traffic.
        repeat (600) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 4'($urandom);
            cmd_ra    = 2'($urandom);
            cmd_rb    = 2'($urandom);
            cmd_rd    = 2'($urandom);
            ld_valid  = ($urandom_range(0, 3) == 0);
            ld_addr   = 2'($urandom);
            ld_data   = 8'($urandom);
            tick();
        end
        idle_inputs();
        repeat (LAT + 3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
